pe_output_writeback: RTL and testbench
======================================

// Module: pe_output_writeback
// PURPOSE
//  Downstream of the PE group: consumes its serialized accumulator stream (DataInValid/DataInRdy/DataIn)
//  and writes every result word into the output SRAM.
//  A small FIFO decouples PE-group backpressure from memory stalls.
//  Address generation turns the per-tile channel order (channel 0..O_PEGroupSize-1) into row-major
//  output addresses. Done pulses once per frame.
// PARAMETERS
//  DataWidth       32   result word width
//  O_PEGroupSize   4    output channels per tile (words per tile)
//  O_PEAddrWidth   2    width of channel counter
//  TileCount       4    tiles per frame
//  TileCountWidth  2    width of tile counter
//  FifoDepth       4    FIFO entries
//  FifoAddrWidth   2    log2(FifoDepth)
//  MemAddrWidth    10   SRAM word-address width
//  RowStride       16   address distance between consecutive channels
// PORTS
//  clk          in   1             clock
//  aclr         in   1             asynchronous, active-low reset
//  Start        in   1             frame start pulse; honoured only in IDLE
//  BaseAddr     in   MemAddrWidth  frame base address, latched on accepted Start
//  DataInValid  in   1             result word valid from PE group
//  DataInRdy    out  1             ready to PE group
//  DataIn       in   DataWidth     result word
//  MemWrEn      out  1             write request to SRAM
//  MemWrRdy     in   1             SRAM accepts the write this cycle
//  MemWrAddr    out  MemAddrWidth  write address
//  MemWrData    out  DataWidth     write data
//  Busy         out  1             high in RUN and FLUSH
//  Done         out  1             one-cycle pulse at frame completion
// BEHAVIOUR
//  Reset (aclr=0, async): state IDLE, FIFO empty, all counters 0.
//   Outputs: DataInRdy=0, MemWrEn=0, MemWrAddr=0, MemWrData=0, Busy=0, Done=0.
//  FSM IDLE -> RUN on Start; RUN -> FLUSH when the last input word is accepted; FLUSH -> DONE when
//   the FIFO is empty and the last write has completed; DONE -> IDLE unconditionally after 1 cycle.
//  IDLE: DataInRdy=0; words offered in IDLE are not accepted.
//   Start latches BaseAddr and clears the in-count, channel counter and tile counter.
//  RUN: DataInRdy = !fifo_full. Accept = DataInValid & DataInRdy.
//   Frame ends after TileCount*O_PEGroupSize accepts. After that, DataInRdy=0 for the rest of the frame.
//  Start outside IDLE is ignored. Done=1 only in DONE.
//  FIFO: registered, first-word-fall-through.
//   A word accepted in cycle n drives MemWrEn/MemWrData in cycle n+1 when the FIFO was empty.
//   No bypass path from input to output.
//   Push and pop in the same cycle leave occupancy unchanged.
//   When full, the push is refused because DataInRdy=0, even if a pop occurs that cycle.
//   Pop on empty is impossible because MemWrEn = !fifo_empty.
//  Write side: MemWrEn = !fifo_empty in RUN and FLUSH; 0 otherwise.
//   Write fires on MemWrEn & MemWrRdy; this pops the FIFO and advances the counters.
//   MemWrAddr, MemWrData and MemWrEn are held stable while MemWrRdy=0.
//  Address: MemWrAddr = BaseAddr + ch*RowStride + tile, mod 2^MemAddrWidth (silent wrap).
//   ch counts 0..O_PEGroupSize-1. On ch wrap, tile increments; tile wraps at TileCount.
//  Reset mid-frame: immediate return to the reset state; no Done; FIFO contents discarded.
// STRUCTURE
//  Shared pe_defs.vh: FSM state encodings (IDLE/RUN/FLUSH/DONE, 2 bits) and common width localparams.
//  Sub-module pe_wb_fifo: sync FIFO (DataWidth, FifoDepth, FifoAddrWidth) with full, empty and count.
//  Top level holds the FSM, the in-count, and the ch/tile address generator.
// TESTING
//  1 Reset, Start with BaseAddr=0x100, 16 words 1..16 back-to-back, MemWrRdy=1 ->
//    writes 0x100,0x110,0x120,0x130,0x101,...,0x133; then Done pulses exactly once.
//  2 MemWrRdy=0 for 10 cycles mid-frame -> DataInRdy drops after 4 buffered words;
//    MemWr* held stable; no loss or duplication.
//  3 BaseAddr=0x3F8 -> the ch=3 tile=3 write goes to (0x3F8+48+3) mod 1024 = 0x02B.
//  4 DataInValid=1 while IDLE, and Start pulsed during RUN -> nothing accepted in IDLE; second Start ignored.
//  5 aclr low after 7 of 16 words -> all outputs 0 next edge; no Done;
//    the following frame starts from ch=0, tile=0.
//  6 Random valid/ready toggling on both sides over 3 frames ->
//    scoreboard shows data order, addresses and a Done count of 3.

Source files
------------

// File: rtl/pe_output_writeback_pkg.sv
// Shared definitions for the PE output writeback block.
// Holds the frame FSM state type and the default sizing constants that the
// writeback top and its FIFO use for their parameter defaults.
package pe_output_writeback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_t;

  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_PE_GROUP_SIZE   = 4;
  localparam int unsigned DEF_PE_ADDR_WIDTH   = 2;
  localparam int unsigned DEF_TILE_COUNT      = 4;
  localparam int unsigned DEF_TILE_CNT_WIDTH  = 2;
  localparam int unsigned DEF_FIFO_DEPTH      = 4;
  localparam int unsigned DEF_FIFO_ADDR_WIDTH = 2;
  localparam int unsigned DEF_MEM_ADDR_WIDTH  = 10;
  localparam int unsigned DEF_ROW_STRIDE      = 16;

endpackage

// File: rtl/pe_output_writeback_fifo.sv
// Synchronous first-word-fall-through FIFO between the PE-group result
// stream and the output SRAM write port.
//  clk, aclr          clock, asynchronous active-low reset
//  push, wr_data      enqueue request and word (ignored while full)
//  pop                dequeue request (ignored while empty)
//  rd_data            head word, valid whenever empty=0
//  full, empty, count occupancy status
module pe_output_writeback_fifo
  import pe_output_writeback_pkg::*;
#(
  parameter int unsigned DataWidth     = DEF_DATA_WIDTH,
  parameter int unsigned FifoDepth     = DEF_FIFO_DEPTH,
  parameter int unsigned FifoAddrWidth = DEF_FIFO_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   push,
  input  logic [DataWidth-1:0]   wr_data,
  input  logic                   pop,
  output logic [DataWidth-1:0]   rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [FifoAddrWidth:0] count
);

  logic [DataWidth-1:0]     mem [FifoDepth];
  logic [FifoAddrWidth-1:0] wr_ptr;
  logic [FifoAddrWidth-1:0] rd_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign full    = (count == (FifoAddrWidth+1)'(FifoDepth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  function automatic logic [FifoAddrWidth-1:0] next_ptr(input logic [FifoAddrWidth-1:0] p);
    return (p == FifoAddrWidth'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage needs no reset: the head is only consumed while empty=0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pe_output_writeback.sv
// PE output writeback: accepts one frame of serialized accumulator words from
// the PE group, buffers them in a small FIFO and writes each to the output SRAM
// at BaseAddr + ch*RowStride + tile (channel-major within a tile).
//  clk, aclr                        clock, asynchronous active-low reset
//  Start, BaseAddr                  frame start (IDLE only) and frame base address
//  DataInValid, DataInRdy, DataIn   result stream from the PE group
//  MemWrEn, MemWrRdy                SRAM write handshake
//  MemWrAddr, MemWrData             SRAM write address / data
//  Busy                             frame in progress (RUN or FLUSH)
//  Done                             one-cycle pulse at frame completion
module pe_output_writeback
  import pe_output_writeback_pkg::*;
#(
  parameter int unsigned DataWidth      = DEF_DATA_WIDTH,
  parameter int unsigned O_PEGroupSize  = DEF_PE_GROUP_SIZE,
  parameter int unsigned O_PEAddrWidth  = DEF_PE_ADDR_WIDTH,
  parameter int unsigned TileCount      = DEF_TILE_COUNT,
  parameter int unsigned TileCountWidth = DEF_TILE_CNT_WIDTH,
  parameter int unsigned FifoDepth      = DEF_FIFO_DEPTH,
  parameter int unsigned FifoAddrWidth  = DEF_FIFO_ADDR_WIDTH,
  parameter int unsigned MemAddrWidth   = DEF_MEM_ADDR_WIDTH,
  parameter int unsigned RowStride      = DEF_ROW_STRIDE
) (
  input  logic                    clk,
  input  logic                    aclr,
  input  logic                    Start,
  input  logic [MemAddrWidth-1:0] BaseAddr,
  input  logic                    DataInValid,
  output logic                    DataInRdy,
  input  logic [DataWidth-1:0]    DataIn,
  output logic                    MemWrEn,
  input  logic                    MemWrRdy,
  output logic [MemAddrWidth-1:0] MemWrAddr,
  output logic [DataWidth-1:0]    MemWrData,
  output logic                    Busy,
  output logic                    Done
);

  localparam int unsigned WordsPerFrame = TileCount * O_PEGroupSize;
  localparam int unsigned InCntWidth    = $clog2(WordsPerFrame + 1);

  wb_state_t                  state;
  logic [InCntWidth-1:0]      in_cnt;
  logic [O_PEAddrWidth-1:0]   ch;
  logic [TileCountWidth-1:0]  tile;
  logic [MemAddrWidth-1:0]    base_addr;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic [FifoAddrWidth:0]     fifo_count;
  logic [DataWidth-1:0]       fifo_head;

  logic                       writing;
  logic                       accept;
  logic                       last_accept;
  logic                       wr_fire;
  logic                       last_write;

  assign writing     = (state == ST_RUN) || (state == ST_FLUSH);
  // Input closes by leaving RUN once the frame's last word is taken.
  assign DataInRdy   = (state == ST_RUN) && !fifo_full;
  assign accept      = DataInValid && DataInRdy;
  assign last_accept = accept && (in_cnt == InCntWidth'(WordsPerFrame - 1));

  assign MemWrEn     = writing && !fifo_empty;
  assign wr_fire     = MemWrEn && MemWrRdy;
  assign MemWrData   = MemWrEn ? fifo_head : '0;
  assign MemWrAddr   = base_addr
                     + MemAddrWidth'(ch) * MemAddrWidth'(RowStride)
                     + MemAddrWidth'(tile);

  assign Busy        = writing;
  assign Done        = (state == ST_DONE);

  // Leave FLUSH on the edge that retires the final buffered word, so DONE
  // coincides with the first cycle the FIFO is empty.
  assign last_write  = fifo_empty
                     || (wr_fire && (fifo_count == {{FifoAddrWidth{1'b0}}, 1'b1}));

  pe_output_writeback_fifo #(
    .DataWidth     (DataWidth),
    .FifoDepth     (FifoDepth),
    .FifoAddrWidth (FifoAddrWidth)
  ) u_fifo (
    .clk     (clk),
    .aclr    (aclr),
    .push    (accept),
    .wr_data (DataIn),
    .pop     (wr_fire),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state     <= ST_IDLE;
      in_cnt    <= '0;
      ch        <= '0;
      tile      <= '0;
      base_addr <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (Start) begin
            state     <= ST_RUN;
            base_addr <= BaseAddr;
            in_cnt    <= '0;
            ch        <= '0;
            tile      <= '0;
          end
        end
        ST_RUN: begin
          if (accept)      in_cnt <= in_cnt + 1'b1;
          if (last_accept) state  <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (last_write) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (wr_fire) begin
        if (ch == O_PEAddrWidth'(O_PEGroupSize - 1)) begin
          ch   <= '0;
          tile <= (tile == TileCountWidth'(TileCount - 1)) ? '0 : tile + 1'b1;
        end else begin
          ch <= ch + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_output_writeback.sv
`timescale 1ns/1ps
module tb_pe_output_writeback;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 10;
  localparam int unsigned NPF = 16;

  logic          clk = 1'b0;
  logic          aclr = 1'b0;
  logic          Start = 1'b0;
  logic [AW-1:0] BaseAddr = '0;
  logic          DataInValid = 1'b0;
  logic [DW-1:0] DataIn = '0;
  logic          MemWrRdy = 1'b0;
  logic          DataInRdy, MemWrEn, Busy, Done;
  logic [AW-1:0] MemWrAddr;
  logic [DW-1:0] MemWrData;

  always #5 clk = ~clk;

  pe_output_writeback #(
    .DataWidth      (32),
    .O_PEGroupSize  (4),
    .O_PEAddrWidth  (2),
    .TileCount      (4),
    .TileCountWidth (2),
    .FifoDepth      (4),
    .FifoAddrWidth  (2),
    .MemAddrWidth   (10),
    .RowStride      (16)
  ) dut (
    .clk         (clk),
    .aclr        (aclr),
    .Start       (Start),
    .BaseAddr    (BaseAddr),
    .DataInValid (DataInValid),
    .DataInRdy   (DataInRdy),
    .DataIn      (DataIn),
    .MemWrEn     (MemWrEn),
    .MemWrRdy    (MemWrRdy),
    .MemWrAddr   (MemWrAddr),
    .MemWrData   (MemWrData),
    .Busy        (Busy),
    .Done        (Done)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Frame view: words accepted so far, words still queued, words written.
  bit            m_active = 1'b0;
  bit            m_done   = 1'b0;
  int            m_acc    = 0;
  int            m_wr     = 0;
  logic [AW-1:0] m_base   = '0;
  logic [DW-1:0] mq[$];

  function automatic logic exp_rdy();
    return m_active && (m_acc < NPF) && (mq.size() < 4);
  endfunction

  function automatic logic exp_en();
    return m_active && (mq.size() > 0);
  endfunction

  // Write k of a frame lands at channel k%4 of tile k/4.
  function automatic logic [AW-1:0] exp_addr();
    return AW'(int'(m_base) + (m_wr % 4) * 16 + (m_wr / 4) % 4);
  endfunction

  initial forever begin : model
    bit af, wf;
    int acc_before;
    @(posedge clk or negedge aclr);
    if (!aclr) begin
      m_active = 1'b0; m_done = 1'b0; m_acc = 0; m_wr = 0; m_base = '0;
      mq.delete();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (Start) begin
        m_active = 1'b1; m_base = BaseAddr; m_acc = 0; m_wr = 0;
      end
    end else begin
      af = exp_rdy() && DataInValid;
      wf = exp_en() && MemWrRdy;
      acc_before = m_acc;
      if (wf) begin void'(mq.pop_front()); m_wr++; end
      if (af) begin mq.push_back(DataIn); m_acc++; end
      if (acc_before == NPF && mq.size() == 0) begin
        m_active = 1'b0; m_done = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare and write log ----------------
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  int            done_cnt = 0;

  initial forever begin : compare
    @(negedge clk);
    chk("rdy",    DataInRdy, exp_rdy());
    chk("wr_en",  MemWrEn,   exp_en());
    chk("busy",   Busy,      m_active);
    chk("done",   Done,      m_done);
    if (!aclr) begin
      chk("rst_addr", MemWrAddr, '0);
      chk("rst_data", MemWrData, '0);
    end else if (exp_en()) begin
      chk("wr_addr", MemWrAddr, exp_addr());
      chk("wr_data", MemWrData, mq[0]);
    end
    if (MemWrEn && MemWrRdy) begin
      log_addr.push_back(MemWrAddr);
      log_data.push_back(MemWrData);
    end
    if (Done) done_cnt++;
  end

  // ---------------- source / sink driver ----------------
  bit            src_on = 1'b0;
  bit            stall  = 1'b0;
  int unsigned   vpct   = 100;
  int unsigned   rpct   = 100;
  logic [DW-1:0] src_data = 32'd1;

  initial forever begin : driver
    bit fire;
    @(negedge clk);
    fire = DataInValid && DataInRdy;
    @(posedge clk);
    #1;
    if (fire) src_data++;
    DataInValid = src_on && ($urandom_range(99) < vpct);
    MemWrRdy    = !stall && ($urandom_range(99) < rpct);
    DataIn      = src_data;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input logic [AW-1:0] base);
    BaseAddr = base;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, done_cnt != d0, 1'b1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total - 1 + 1);
    $fatal(1, "time limit");
  end

  int lb;

  initial begin : main
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_rdy",  DataInRdy, 1'b0);
    chk("reset_en",   MemWrEn,   1'b0);
    chk("reset_busy", Busy,      1'b0);
    chk("reset_done", Done,      1'b0);
    chk("reset_addr", MemWrAddr, '0);
    chk("reset_data", MemWrData, '0);
    tick();
    aclr = 1'b1;
    tick();

    // Test 1 (+ IDLE refusal): words offered in IDLE, then a clean frame at 0x100
    src_data = 32'd1; vpct = 100; rpct = 100; src_on = 1'b1;
    repeat (4) tick();
    chk("idle_no_accept", src_data, 32'd1);
    lb = log_addr.size();
    start_frame(10'h100);
    wait_done(100, "t1_done_timeout");
    repeat (3) tick();
    src_on = 1'b0;
    chk("t1_count",   log_addr.size() - lb, NPF);
    chk("t1_addr0",   log_addr[lb+0],  10'h100);
    chk("t1_addr1",   log_addr[lb+1],  10'h110);
    chk("t1_addr3",   log_addr[lb+3],  10'h130);
    chk("t1_addr4",   log_addr[lb+4],  10'h101);
    chk("t1_addr15",  log_addr[lb+15], 10'h133);
    chk("t1_data0",   log_data[lb+0],  32'd1);
    chk("t1_data15",  log_data[lb+15], 32'd16);
    chk("t1_done_once", done_cnt, 1);

    // Test 2 (+ Start during RUN): memory stall mid-frame at base 0x080
    src_data = 32'd101; src_on = 1'b1;
    lb = log_addr.size();
    start_frame(10'h080);
    tick();
    BaseAddr = 10'h2AA;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (2) tick();
    stall = 1'b1;
    repeat (10) tick();
    chk("t2_stall_rdy_low", DataInRdy, 1'b0);
    chk("t2_stall_en_held", MemWrEn,   1'b1);
    stall = 1'b0;
    wait_done(100, "t2_done_timeout");
    src_on = 1'b0;
    chk("t2_count", log_addr.size() - lb, NPF);
    for (int i = 0; i < NPF; i++) chk("t2_order", log_data[lb+i], 32'(101 + i));
    chk("t2_addr0",  log_addr[lb+0],  10'h080);
    chk("t2_addr15", log_addr[lb+15], 10'h0B3);
    chk("t2_done",   done_cnt, 2);

    // Test 3: address wrap at base 0x3F8
    src_data = 32'd201; src_on = 1'b1;
    lb = log_addr.size();
    start_frame(10'h3F8);
    wait_done(100, "t3_done_timeout");
    src_on = 1'b0;
    chk("t3_addr0",  log_addr[lb+0],  10'h3F8);
    chk("t3_addr3",  log_addr[lb+3],  10'h028);
    chk("t3_addr15", log_addr[lb+15], 10'h02B);
    chk("t3_done",   done_cnt, 3);

    // Test 5: reset after 7 words, then a fresh frame
    src_data = 32'd301; src_on = 1'b1;
    start_frame(10'h040);
    begin
      int n;
      n = 0;
      while (src_data != 32'd308 && n < 50) begin tick(); n++; end
      chk("t5_seven_timeout", src_data, 32'd308);
    end
    aclr = 1'b0;
    src_on = 1'b0;
    #1;
    chk("t5_rst_rdy",  DataInRdy, 1'b0);
    chk("t5_rst_en",   MemWrEn,   1'b0);
    chk("t5_rst_busy", Busy,      1'b0);
    chk("t5_rst_done", Done,      1'b0);
    chk("t5_rst_addr", MemWrAddr, '0);
    chk("t5_rst_data", MemWrData, '0);
    repeat (2) tick();
    aclr = 1'b1;
    repeat (3) tick();
    chk("t5_no_done", done_cnt, 3);
    src_data = 32'd401; src_on = 1'b1;
    lb = log_addr.size();
    start_frame(10'h040);
    wait_done(100, "t5_done_timeout");
    src_on = 1'b0;
    chk("t5_addr0", log_addr[lb+0], 10'h040);
    chk("t5_addr1", log_addr[lb+1], 10'h050);
    chk("t5_data0", log_data[lb+0], 32'd401);
    chk("t5_done",  done_cnt, 4);

    // Test 6: random handshakes on both sides over 3 frames
    src_data = 32'd501; vpct = 60; rpct = 50; src_on = 1'b1;
    lb = log_addr.size();
    for (int f = 0; f < 3; f++) begin
      start_frame(AW'(10'h013 + 10'h100 * f));
      wait_done(600, "t6_done_timeout");
    end
    src_on = 1'b0;
    repeat (3) tick();
    chk("t6_count",  log_addr.size() - lb, 3 * NPF);
    chk("t6_data0",  log_data[lb+0],  32'd501);
    chk("t6_data47", log_data[lb+47], 32'd548);
    chk("t6_addr47", log_addr[lb+47], 10'h246);
    chk("t6_done",   done_cnt, 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
